// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg: shared width default, RV32M divide op encodings and FSM states
// for the iterative divider.
package riscv_div_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3[1:0] of the RV32M divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIVIDE,
    ST_FIX,
    ST_DONE
  } div_state_e;

  function automatic logic is_signed_op(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/riscv_div_unit_if.sv
// riscv_div_unit_if: start/done request interface between the execute stage
// (master) and the iterative divider (slave).
interface riscv_div_unit_if
  import riscv_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            ready;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor,
    input  ready, busy, valid, result
  );

  modport slave (
    input  start, op, dividend, divisor,
    output ready, busy, valid, result
  );

endinterface

// File: rtl/riscv_div_unit_step.sv
// div_step: one combinational restoring-division iteration; the FSM registers
// its outputs once per cycle.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] div,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The shifted partial remainder keeps its carry-out bit so unsigned divisors
  // above 2^(XLEN-1) still compare correctly.
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, div};

  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    rem_next = shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/riscv_div_unit.sv
// riscv_div_unit: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish early when |dividend| < |divisor|.
module riscv_div_unit
  import riscv_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  riscv_div_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  div_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_quo_q, neg_rem_q;

  logic            ready, valid;
  logic            op_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, early_out;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] fix_quo, fix_rem;

  assign op_signed = is_signed_op(op_q);
  assign a_neg     = op_signed && a_q[XLEN-1];
  assign b_neg     = op_signed && b_q[XLEN-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;
  assign div_zero  = (b_q == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = !div_zero && (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  // -2^31 / -1 needs no special case: magnitude 2^31 negates back to itself.
  assign fix_quo = neg_quo_q ? -quo_q : quo_q;
  assign fix_rem = neg_rem_q ? -rem_q : rem_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .div      (div_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (div_zero || early_out) state_d = ST_DONE;
        else                       state_d = ST_DIVIDE;
      end
      ST_DIVIDE: begin
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: state_d = ST_DONE;
      ST_DONE: begin
        ready = 1'b1;
        valid = 1'b1;
        state_d = bus.start ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready  = ready;
  assign bus.busy   = !ready;
  assign bus.valid  = valid;
  assign bus.result = result_q;

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every datapath register so an aborted
    // operation leaves no stale operands, partial results or result value.
    if (!reset) begin
      op_q      <= OP_DIV;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            op_q <= div_op_e'(bus.op);
            a_q  <= bus.dividend;
            b_q  <= bus.divisor;
          end
        end
        ST_LOAD: begin
          if (div_zero) begin
            result_q <= is_rem_op(op_q) ? a_q : '1;
          end else if (early_out) begin
            result_q <= is_rem_op(op_q) ? a_q : '0;
          end else begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            div_q     <= b_mag;
            cnt_q     <= CW'(XLEN - 1);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
          end
        end
        ST_DIVIDE: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - CW'(1);
        end
        ST_FIX: begin
          result_q <= is_rem_op(op_q) ? fix_rem : fix_quo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_div_unit.sv
// tb_riscv_div_unit: scoreboard bench for riscv_div_unit with a reference model
// built on 64-bit signed/unsigned arithmetic.
module tb_riscv_div_unit;
  import riscv_div_pkg::*;

  localparam int XLEN = 32;
  // Edges from the accepting edge to the edge that raises valid.
  localparam int LAT_FULL  = XLEN + 2;
  localparam int LAT_SHORT = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  riscv_div_unit_if #(.XLEN(XLEN)) bus();

  riscv_div_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] result;
    int          accept_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   r = sa / sb;
      2'b01:   r = ua / ub;
      2'b10:   r = sa % sb;
      default: r = ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint ma, mb;
    ma = op[0] ? longint'(a) : longint'($signed(a));
    mb = op[0] ? longint'(b) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 32'd0) return LAT_SHORT;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return LAT_SHORT;
`endif
    return LAT_FULL;
  endfunction

  task automatic push(input string name, input logic [31:0] exp, input int acc, input int lat);
    exp_t e;
    e.name       = name;
    e.result     = exp;
    e.accept_cyc = acc;
    e.lat        = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, bus.result, e.result);
        check({e.name, "_latency"}, cyc - e.accept_cyc, e.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) begin
      check({name, "_ready_timeout"}, bus.ready, 1'b1);
      return;
    end
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    push(name, exp, cyc + 1, ref_latency(op, a, b));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op       = 2'($urandom);
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    check({name, "_busy"}, {bus.busy, bus.ready}, 2'b10);
  endtask

  // start held high throughout with operands changing every cycle: only the
  // operands present at each accepting edge may produce a result.
  task automatic run_held(input int n_ops);
    int          accepted, prev_acc, prev_lat, guard, lat;
    logic [1:0]  op;
    logic [31:0] a, b;
    accepted = 0;
    prev_acc = -1;
    prev_lat = 0;
    guard    = 0;
    bus.start = 1'b1;
    while (accepted < n_ops && guard < 500) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (b == 32'd0) b = 32'd3;
      bus.op       = op;
      bus.dividend = a;
      bus.divisor  = b;
      if (bus.ready) begin
        lat = ref_latency(op, a, b);
        if (prev_acc >= 0) check("held_back_to_back_gap", cyc + 1 - prev_acc, prev_lat + 1);
        push("held", ref_result(op, a, b), cyc + 1, lat);
        prev_acc = cyc + 1;
        prev_lat = lat;
        accepted++;
      end
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    check("held_accept_count", accepted, n_ops);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel;

    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_ready",  bus.ready,  1'b1);
    check("reset_busy",   bus.busy,   1'b0);
    check("reset_valid",  bus.valid,  1'b0);
    check("reset_result", bus.result, 32'd0);
    reset = 1'b1;

    issue("divu_100_7",      OP_DIVU, 32'd100,        32'd7,          32'd14);
    issue("remu_100_7",      OP_REMU, 32'd100,        32'd7,          32'd2);
    issue("div_m7_2",        OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    issue("rem_m7_2",        OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    issue("rem_7_m2",        OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1);
    issue("div_overflow",    OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    issue("rem_overflow",    OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    issue("divu_5_0",        OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF);
    issue("rem_5_0",         OP_REM,  32'd5,          32'd0,          32'd5);
    issue("divu_big_div",    OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1);
    issue("remu_big_div",    OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE);
    drain();

    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom);
      a   = $urandom;
      b   = $urandom;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      issue("rand", op, a, b, ref_result(op, a, b));
    end
    drain();

    @(negedge clk);
    run_held(3);
    drain();

    // Abort: reset asserted during the 10th DIVIDE cycle, result 14 held before.
    issue("pre_abort", OP_DIVU, 32'd100, 32'd7, 32'd14);
    drain();
    issue("abort", OP_DIVU, 32'hFFFF_FFF0, 32'd3, 32'h5555_5550);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready",  bus.ready,  1'b1);
    check("abort_busy",   bus.busy,   1'b0);
    check("abort_valid",  bus.valid,  1'b0);
    check("abort_result", bus.result, 32'd0);
    exp_q.delete();
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("post_abort_ready", bus.ready, 1'b1);

    issue("post_abort_rem", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
